// File: rtl/alu_op_sequencer_pkg.sv
// Purpose  : shared opcodes, ALU function codes and FSM state type for the ALU op sequencer.
// Latency  : n/a (definitions only).
// Backpr.  : n/a.
// Contents : OP_* command opcodes, FUNC_* ALU encodings, state_t, opcode classifier helpers.
package alu_seq_pkg;

  localparam int DATA_W      = 16;
  localparam int SHAMT_DEF_W = 4;

  // Command opcodes; 10..15 are illegal.
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_NOR = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;
  localparam logic [3:0] OP_EQ  = 4'd8;
  localparam logic [3:0] OP_NE  = 4'd9;

  // ALU function encodings.
  localparam logic [2:0] FUNC_ADD = 3'b000;
  localparam logic [2:0] FUNC_SUB = 3'b001;
  localparam logic [2:0] FUNC_AND = 3'b010;
  localparam logic [2:0] FUNC_OR  = 3'b011;
  localparam logic [2:0] FUNC_NOR = 3'b100;
  localparam logic [2:0] FUNC_XOR = 3'b101;
  localparam logic [2:0] FUNC_SHL = 3'b110;
  localparam logic [2:0] FUNC_SHR = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_SHIFT = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  function automatic logic op_is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL);
  endfunction

  function automatic logic op_is_cmp(input logic [3:0] op);
    return (op == OP_EQ) || (op == OP_NE);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Purpose  : bundles the command, ALU-drive and response signals of the ALU op sequencer.
// Latency  : n/a (wiring only).
// Backpr.  : cmd_valid/cmd_ready and rsp_valid/rsp_ready handshakes.
// Modports : slave = sequencer (takes commands, drives ALU inputs and responses);
//            master = surrounding logic (issues commands, returns ALU result, consumes responses).
interface alu_op_sequencer_if #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [3:0]         cmd_op;
  logic [WIDTH-1:0]   cmd_a;
  logic [WIDTH-1:0]   cmd_b;
  logic [SHAMT_W-1:0] cmd_shamt;

  logic [WIDTH-1:0]   alu_a;
  logic [WIDTH-1:0]   alu_b;
  logic [2:0]         alu_func;
  logic [WIDTH-1:0]   alu_r;
  logic               alu_zf;

  logic               rsp_valid;
  logic               rsp_ready;
  logic [WIDTH-1:0]   rsp_result;
  logic               rsp_zf;
  logic               rsp_err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_shamt, alu_r, alu_zf, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_func, rsp_valid, rsp_result, rsp_zf, rsp_err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_shamt, alu_r, alu_zf, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_func, rsp_valid, rsp_result, rsp_zf, rsp_err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Purpose  : turns one command into one or more cycles of an external combinational ALU.
// Latency  : accept->rsp_valid: 1 cycle illegal, 2 cycles single/compare/zero-shift, N+1 for shift by N.
// Backpr.  : no overlap; cmd_ready only in IDLE, response held until rsp_ready.
// Ports    : clk, rst_n (async active-low); bus (alu_op_sequencer_if.slave) carries cmd_*, alu_*, rsp_*.
// Config   : define ALU_SEQ_CMP_EN to support EQ/NE; otherwise opcodes 8/9 decode as illegal.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH   = DATA_W,
  parameter int SHAMT_W = SHAMT_DEF_W
) (
  input logic               clk,
  input logic               rst_n,
  alu_op_sequencer_if.slave bus
);

  localparam logic [SHAMT_W-1:0] CNT_ONE = {{(SHAMT_W-1){1'b0}}, 1'b1};

  state_t             state;
  logic [3:0]         op_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic [WIDTH-1:0]   alu_a_q;   // doubles as the shift accumulator
  logic [WIDTH-1:0]   alu_b_q;
  logic [2:0]         alu_func_q;
  logic               rsp_valid_q;
  logic [WIDTH-1:0]   rsp_result_q;
  logic               rsp_zf_q;
  logic               rsp_err_q;

  logic               op_legal;
  logic [WIDTH-1:0]   exec_result;

  always_comb begin
    op_legal = (bus.cmd_op <= OP_XOR) || op_is_shift(bus.cmd_op);
`ifdef ALU_SEQ_CMP_EN
    op_legal = op_legal || op_is_cmp(bus.cmd_op);
`endif
  end

  // Result captured at the end of the single EXEC cycle. A zero-amount shift
  // returns A unchanged, which is still held in alu_a_q.
  always_comb begin
    exec_result = bus.alu_r;
    if (op_is_shift(op_q)) begin
      exec_result = alu_a_q;
    end
`ifdef ALU_SEQ_CMP_EN
    else if (op_q == OP_EQ) begin
      exec_result = {{(WIDTH-1){1'b0}}, bus.alu_zf};
    end else if (op_q == OP_NE) begin
      exec_result = {{(WIDTH-1){1'b0}}, ~bus.alu_zf};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      op_q         <= '0;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_func_q   <= FUNC_ADD;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_zf_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            op_q  <= bus.cmd_op;
            cnt_q <= bus.cmd_shamt;
            if (!op_legal) begin
              // No ALU cycle: respond straight away with the error result.
              state        <= S_RESP;
              rsp_valid_q  <= 1'b1;
              rsp_result_q <= '0;
              rsp_zf_q     <= 1'b1;
              rsp_err_q    <= 1'b1;
            end else if (op_is_shift(bus.cmd_op) && (bus.cmd_shamt != '0)) begin
              state      <= S_SHIFT;
              alu_a_q    <= bus.cmd_a;
              alu_b_q    <= '0;
              alu_func_q <= (bus.cmd_op == OP_SLL) ? FUNC_SHL : FUNC_SHR;
            end else begin
              state   <= S_EXEC;
              alu_a_q <= bus.cmd_a;
              if (op_is_shift(bus.cmd_op)) begin
                alu_b_q    <= '0;
                alu_func_q <= FUNC_ADD;
              end else if (op_is_cmp(bus.cmd_op)) begin
                alu_b_q    <= bus.cmd_b;
                alu_func_q <= FUNC_SUB;
              end else begin
                alu_b_q    <= bus.cmd_b;
                alu_func_q <= bus.cmd_op[2:0];
              end
            end
          end
        end

        S_EXEC: begin
          state        <= S_RESP;
          rsp_valid_q  <= 1'b1;
          rsp_result_q <= exec_result;
          rsp_zf_q     <= (exec_result == '0);
          rsp_err_q    <= 1'b0;
          alu_a_q      <= '0;
          alu_b_q      <= '0;
          alu_func_q   <= FUNC_ADD;
        end

        S_SHIFT: begin
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state        <= S_RESP;
            rsp_valid_q  <= 1'b1;
            rsp_result_q <= bus.alu_r;
            rsp_zf_q     <= (bus.alu_r == '0);
            rsp_err_q    <= 1'b0;
            alu_a_q      <= '0;
            alu_func_q   <= FUNC_ADD;
          end else begin
            alu_a_q <= bus.alu_r;
          end
        end

        S_RESP: begin
          if (bus.rsp_ready) begin
            state       <= S_IDLE;
            rsp_valid_q <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = (state == S_IDLE);
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_func   = alu_func_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_zf     = rsp_zf_q;
  assign bus.rsp_err    = rsp_err_q;

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Multi-cycle command sequencer that drives the 16-bit combinational ALU from its input side (operands, 3-bit function) and collects its result and zero flag. It turns one accepted command into one or more ALU cycles. Shifts by N are built from N shift-by-1 ALU cycles, and equality compares are built from subtraction plus the zero flag. It sits between the control/decode logic and the ALU, with valid/ready handshakes on both the command side and the response side.

## Interface
- WIDTH, 16, datapath width (must match ALU)
- SHAMT_W, 4, shift-amount width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  4  operation code (see Operation)
- cmd_a  in  WIDTH  operand A
- cmd_b  in  WIDTH  operand B
- cmd_shamt  in  SHAMT_W  shift amount, used only by SLL/SRL
- alu_a  out  WIDTH  ALU operand A
- alu_b  out  WIDTH  ALU operand B
- alu_func  out  3  ALU function: 000 add, 001 sub, 010 and, 011 or, 100 nor, 101 xor, 110 shl1, 111 shr1
- alu_r  in  WIDTH  ALU result
- alu_zf  in  1  ALU zero flag
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_result  out  WIDTH  final result
- rsp_zf  out  1  1 when rsp_result == 0
- rsp_err  out  1  illegal opcode

## Operation
- Opcodes:
  - 0–5: ADD, SUB, AND, OR, NOR, XOR. Single ALU cycle; alu_func equals opcode[2:0].
  - 6 SLL, 7 SRL: shift A by cmd_shamt.
  - 8 EQ, 9 NE: compare A and B.
  - 10–15: illegal.
- States: IDLE, EXEC, SHIFT, RESP.
- IDLE:
  - cmd_ready=1.
  - Handshake on cmd_valid&&cmd_ready. It latches op, A, B, shamt and sets cnt=shamt.
  - Next state is EXEC, or SHIFT if op is SLL/SRL with shamt≠0, or RESP with rsp_err=1 if op is illegal.
- EXEC drives the ALU for exactly one cycle, then goes to RESP:
  - ops 0–5: alu_a=A, alu_b=B, func=op[2:0]; result is alu_r.
  - EQ/NE: func=001; EQ result={15'b0, alu_zf}; NE result={15'b0, ~alu_zf}.
  - SLL/SRL with shamt=0: func=000, alu_b forced to 0; result is A.
- SHIFT:
  - alu_a=acc (acc loaded from A on accept), alu_b=0, func=110 (SLL) or 111 (SRL).
  - Each cycle: acc<=alu_r, cnt<=cnt−1.
  - The cycle with cnt==1 is the last one; next state is RESP with result=alu_r.
- RESP:
  - rsp_valid=1; rsp_result, rsp_zf and rsp_err are held stable.
  - Leaves for IDLE on rsp_ready.
  - cmd_ready=0.
- Illegal op: rsp_result=0, rsp_zf=1, rsp_err=1. No ALU cycle is issued.
- Outside EXEC/SHIFT, alu_a, alu_b and alu_func are driven to 0.
- rsp_zf is always computed as (rsp_result==0), independent of alu_zf.
- Arithmetic wraps modulo 2^WIDTH; no carry or overflow reporting.

## Timing
- Reset (async assert, sync release):
  - state=IDLE.
  - rsp_valid=0, rsp_result=0, rsp_zf=0, rsp_err=0.
  - alu_a=0, alu_b=0, alu_func=0.
  - cmd_ready reads 1 because it is decoded from IDLE. No handshake is registered while rst_n=0.
- Latency, measured from the accept edge (cycle 0) to rsp_valid high:
  - single-cycle ops, EQ/NE, zero shift: 2 cycles.
  - shift by N>0: N+1 cycles.
  - illegal op: 1 cycle.
- Throughput: no overlap. The next command can be accepted in the cycle after the rsp handshake completes.
- rsp_ready held high in RESP: exactly one rsp_valid cycle.
- cmd_valid held while cmd_ready=0: ignored; the command is not latched.
- Reset asserted mid-operation:
  - immediate return to IDLE, rsp_valid=0.
  - the in-flight command is discarded; no response is produced.
- Maximum shamt of 15 takes 15 SHIFT cycles. The result is exact, not clamped.

## Configuration
- ALU_SEQ_CMP_EN:
  - Defined: EQ/NE are supported as above.
  - Undefined: opcodes 8 and 9 decode as illegal (rsp_err=1, result 0, 1-cycle latency), and the compare result mux is omitted.

## Structure
- Package alu_seq_pkg holds:
  - opcode localparams (OP_ADD…OP_NE).
  - ALU function encodings (FUNC_ADD…FUNC_SHR).
  - the state enum (S_IDLE, S_EXEC, S_SHIFT, S_RESP).
- No sub-module is required. The ALU is instantiated alongside, not inside, the sequencer.
- The shift counter and accumulator stay inline.

## Test plan
- ADD A=16'h7FFF, B=16'h0001: rsp_result=16'h8000, rsp_zf=0, rsp_valid 2 cycles after accept. SUB 16'h0005−16'h0005: rsp_result=0, rsp_zf=1.
- SLL A=16'h0001, shamt=15: exactly 15 cycles with alu_func=110, then rsp_result=16'h8000. SRL A=16'h8000, shamt=0: one EXEC cycle with func=000, result 16'h8000.
- EQ A=B=16'h1234: result 16'h0001, rsp_zf=0. NE with the same operands: result 0, rsp_zf=1. Without ALU_SEQ_CMP_EN, both give rsp_err=1.
- Illegal op 4'hF: rsp_err=1, rsp_result=0, rsp_zf=1, latency 1. alu_func stays 0 throughout.
- rsp_ready held low for 5 cycles: outputs stable and cmd_ready=0; a cmd_valid pulse during those cycles is not accepted.
- rst_n pulsed low during cycle 3 of a shamt=8 shift: rsp_valid never rises; the next command after reset completes normally.
